// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: round-robin sharing between a CPU and a host/loader,
// with a host-exclusive LOCKED mode and a one-cycle read-valid return pipeline.
module mem_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    // CPU port
    input  logic             c_req,
    input  logic             c_we,
    input  logic [WIDTH-1:0] c_adr,
    input  logic [WIDTH-1:0] c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic             cpu_stall,
    // host/loader port
    input  logic             h_req,
    input  logic             h_we,
    input  logic             h_lock,
    input  logic [WIDTH-1:0] h_adr,
    input  logic [WIDTH-1:0] h_wdata,
    output logic             h_gnt,
    output logic             h_rvalid,
    // memory side
    output logic             m_en,
    output logic             m_we,
    output logic [WIDTH-1:0] m_adr,
    output logic [WIDTH-1:0] m_wdata,
    input  logic [WIDTH-1:0] m_rdata,
    output logic [WIDTH-1:0] rdata
);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    state_t state_q;
    state_t state_d;
    logic   last_owner_q;
    logic   c_rv_q;
    logic   h_rv_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: lock is entered/left on the edge that samples h_lock
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (h_lock)  state_d = LOCKED;
            LOCKED:  if (!h_lock) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // Grant decode; reset masks grants so every output shows its reset value at once
    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    if (c_req && h_req) begin
                        c_gnt = (last_owner_q == OWNER_HOST);
                        h_gnt = (last_owner_q == OWNER_CPU);
                    end else begin
                        c_gnt = c_req;
                        h_gnt = h_req;
                    end
                end
                LOCKED: begin
                    h_gnt = h_req;
                end
                default: begin
                    c_gnt = 1'b0;
                    h_gnt = 1'b0;
                end
            endcase
        end
    end

    // Memory-side mux driven by whichever port holds the grant
    always_comb begin
        m_en    = c_gnt | h_gnt;
        m_we    = 1'b0;
        m_adr   = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_adr   = c_adr;
            m_wdata = c_wdata;
        end else if (h_gnt) begin
            m_we    = h_we;
            m_adr   = h_adr;
            m_wdata = h_wdata;
        end
    end

    assign cpu_stall = c_req & ~c_gnt;
    assign rdata     = m_rdata;
    assign c_rvalid  = c_rv_q;
    assign h_rvalid  = h_rv_q;

    // Round-robin history and read-valid pipeline (cleared by reset, so pending reads are dropped)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWNER_HOST;
            c_rv_q       <= 1'b0;
            h_rv_q       <= 1'b0;
        end else begin
            if (c_gnt) begin
                last_owner_q <= OWNER_CPU;
            end else if (h_gnt) begin
                last_owner_q <= OWNER_HOST;
            end
            c_rv_q <= c_gnt & ~c_we;
            h_rv_q <= h_gnt & ~h_we;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised bench for mem_arbiter: grants, mux, lock mode,
// read-valid pipeline and reset behaviour.
module tb_mem_arbiter;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         c_req = 1'b0, c_we = 1'b0;
    logic [W-1:0] c_adr = '0, c_wdata = '0;
    logic         c_gnt, c_rvalid, cpu_stall;
    logic         h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [W-1:0] h_adr = '0, h_wdata = '0;
    logic         h_gnt, h_rvalid;
    logic         m_en, m_we;
    logic [W-1:0] m_adr, m_wdata, rdata;
    logic [W-1:0] m_rdata = '0;

    int total = 0;
    int passed = 0;

    mem_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .cpu_stall(cpu_stall),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_adr(h_adr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge, then let combinational outputs settle
    task automatic drive(input logic cr, input logic cw, input logic [W-1:0] ca, input logic [W-1:0] cd,
                         input logic hr, input logic hw, input logic hl, input logic [W-1:0] ha,
                         input logic [W-1:0] hd, input logic [W-1:0] rd);
        @(negedge clk);
        c_req = cr; c_we = cw; c_adr = ca; c_wdata = cd;
        h_req = hr; h_we = hw; h_lock = hl; h_adr = ha; h_wdata = hd;
        m_rdata = rd;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 8'h11, 8'h00, 1, 0, 0, 8'h22, 8'h00, 8'h00);
        total++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, m_en, m_we, cpu_stall} !== 7'b0000001) begin
            $display("FAIL reset_ctrl: got %b expected 0000001", {c_gnt, h_gnt, c_rvalid, h_rvalid, m_en, m_we, cpu_stall});
        end else passed++;
        drive(1, 0, 8'h11, 8'h33, 1, 0, 0, 8'h22, 8'h44, 8'h00);
        total++;
        if ({m_adr, m_wdata, c_rvalid, h_rvalid} !== 18'h0) begin
            $display("FAIL reset_bus: got adr=%h wdata=%h rv=%b%b expected 0", m_adr, m_wdata, c_rvalid, h_rvalid);
        end else passed++;
    endtask

    task automatic test_round_robin();
        @(posedge clk);
        #2 reset = 1'b0;
        drive(1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 8'h00);
        total++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, cpu_stall, m_adr} !== {5'b10000, 8'h01}) begin
            $display("FAIL rr_cycle1: got g=%b%b rv=%b%b st=%b adr=%h expected 10 00 0 01", c_gnt, h_gnt, c_rvalid, h_rvalid, cpu_stall, m_adr);
        end else passed++;
        drive(1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 8'h77);
        total++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, cpu_stall, m_adr, rdata} !== {5'b01101, 8'h02, 8'h77}) begin
            $display("FAIL rr_cycle2: got g=%b%b rv=%b%b st=%b adr=%h rd=%h expected 01 10 1 02 77", c_gnt, h_gnt, c_rvalid, h_rvalid, cpu_stall, m_adr, rdata);
        end else passed++;
        drive(1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00, 8'h88);
        total++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, m_adr, rdata} !== {4'b1001, 8'h01, 8'h88}) begin
            $display("FAIL rr_cycle3: got g=%b%b rv=%b%b adr=%h rd=%h expected 10 01 01 88", c_gnt, h_gnt, c_rvalid, h_rvalid, m_adr, rdata);
        end else passed++;
        drive(0, 0, 8'h01, 8'h00, 0, 0, 0, 8'h02, 8'h00, 8'h99);
        total++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, m_en, m_adr, rdata} !== {5'b00100, 8'h00, 8'h99}) begin
            $display("FAIL rr_idle: got g=%b%b rv=%b%b en=%b adr=%h rd=%h expected 00 10 0 00 99", c_gnt, h_gnt, c_rvalid, h_rvalid, m_en, m_adr, rdata);
        end else passed++;
    endtask

    task automatic test_write();
        drive(1, 1, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        total++;
        if ({c_gnt, h_gnt, m_en, m_we, m_adr, m_wdata} !== {4'b1011, 8'h10, 8'hA5}) begin
            $display("FAIL cpu_write: got g=%b%b en=%b we=%b adr=%h wd=%h expected 10 1 1 10 a5", c_gnt, h_gnt, m_en, m_we, m_adr, m_wdata);
        end else passed++;
        drive(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h22, 8'h5A, 8'h00);
        total++;
        if ({c_gnt, h_gnt, c_rvalid, m_we, m_adr, m_wdata} !== {4'b0101, 8'h22, 8'h5A}) begin
            $display("FAIL host_write: got g=%b%b crv=%b we=%b adr=%h wd=%h expected 01 0 1 22 5a", c_gnt, h_gnt, c_rvalid, m_we, m_adr, m_wdata);
        end else passed++;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        total++;
        if ({c_rvalid, h_rvalid, m_en} !== 3'b000) begin
            $display("FAIL write_no_rvalid: got rv=%b%b en=%b expected 000", c_rvalid, h_rvalid, m_en);
        end else passed++;
    endtask

    task automatic test_lock();
        // lock rises while the CPU wins the ARB tie (last owner was host)
        drive(1, 0, 8'h30, 8'h00, 1, 1, 1, 8'h40, 8'h11, 8'h00);
        total++;
        if ({c_gnt, h_gnt, cpu_stall, m_we, m_adr} !== {4'b1000, 8'h30}) begin
            $display("FAIL lock_rise_arb: got g=%b%b st=%b we=%b adr=%h expected 10 0 0 30", c_gnt, h_gnt, cpu_stall, m_we, m_adr);
        end else passed++;
        drive(1, 0, 8'h30, 8'h00, 1, 1, 1, 8'h41, 8'h12, 8'h3C);
        total++;
        if ({c_gnt, h_gnt, c_rvalid, cpu_stall, m_we, m_adr, rdata} !== {5'b01111, 8'h41, 8'h3C}) begin
            $display("FAIL lock_rvalid: got g=%b%b crv=%b st=%b we=%b adr=%h rd=%h expected 01 1 1 1 41 3c", c_gnt, h_gnt, c_rvalid, cpu_stall, m_we, m_adr, rdata);
        end else passed++;
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 8'h30, 8'h00, 1, 1, 1, 8'h42, 8'h13, 8'h00);
            total++;
            if ({c_gnt, h_gnt, c_rvalid, cpu_stall} !== 4'b0101) begin
                $display("FAIL lock_hold%0d: got g=%b%b crv=%b st=%b expected 01 0 1", i, c_gnt, h_gnt, c_rvalid, cpu_stall);
            end else passed++;
        end
        drive(1, 0, 8'h30, 8'h00, 0, 0, 1, 8'h42, 8'h13, 8'h00);
        total++;
        if ({c_gnt, h_gnt, m_en, cpu_stall} !== 4'b0001) begin
            $display("FAIL lock_no_host: got g=%b%b en=%b st=%b expected 00 0 1", c_gnt, h_gnt, m_en, cpu_stall);
        end else passed++;
        // lock dropped: still LOCKED this cycle, ARB from the next one
        drive(1, 0, 8'h30, 8'h00, 1, 1, 0, 8'h43, 8'h14, 8'h00);
        total++;
        if ({c_gnt, h_gnt, cpu_stall} !== 3'b011) begin
            $display("FAIL lock_fall: got g=%b%b st=%b expected 01 1", c_gnt, h_gnt, cpu_stall);
        end else passed++;
        drive(1, 0, 8'h30, 8'h00, 1, 1, 0, 8'h43, 8'h14, 8'h00);
        total++;
        if ({c_gnt, h_gnt, cpu_stall} !== 3'b100) begin
            $display("FAIL unlock_cpu: got g=%b%b st=%b expected 10 0", c_gnt, h_gnt, cpu_stall);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, W'(8'h50 + i), 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
            total++;
            if ({c_gnt, c_rvalid, m_en, m_adr} !== {3'b111, W'(8'h50 + i)}) begin
                $display("FAIL b2b_%0d: got g=%b rv=%b en=%b adr=%h expected 1 1 1 %h", i, c_gnt, c_rvalid, m_en, m_adr, W'(8'h50 + i));
            end else passed++;
        end
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        total++;
        if ({c_gnt, c_rvalid, m_en} !== 3'b010) begin
            $display("FAIL b2b_tail: got g=%b rv=%b en=%b expected 0 1 0", c_gnt, c_rvalid, m_en);
        end else passed++;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        total++;
        if ({c_rvalid, h_rvalid} !== 2'b00) begin
            $display("FAIL b2b_drain: got rv=%b%b expected 00", c_rvalid, h_rvalid);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h60, 8'h00, 8'h00);
        total++;
        if ({c_gnt, h_gnt, m_adr} !== {2'b01, 8'h60}) begin
            $display("FAIL pre_reset_host: got g=%b%b adr=%h expected 01 60", c_gnt, h_gnt, m_adr);
        end else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, m_en, m_we, cpu_stall, m_adr, m_wdata} !== 23'h0) begin
            $display("FAIL async_reset: got g=%b%b rv=%b%b en=%b we=%b st=%b adr=%h wd=%h expected all 0",
                     c_gnt, h_gnt, c_rvalid, h_rvalid, m_en, m_we, cpu_stall, m_adr, m_wdata);
        end else passed++;
        @(posedge clk);
        #1;
        total++;
        if (h_rvalid !== 1'b0) begin
            $display("FAIL reset_drop_rvalid: got %b expected 0", h_rvalid);
        end else passed++;
        #1 reset = 1'b0;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        total++;
        if ({c_rvalid, h_rvalid} !== 2'b00) begin
            $display("FAIL post_reset_rvalid: got %b%b expected 00", c_rvalid, h_rvalid);
        end else passed++;
        drive(1, 0, 8'h70, 8'h00, 1, 0, 0, 8'h71, 8'h00, 8'h00);
        total++;
        if ({c_gnt, h_gnt} !== 2'b10) begin
            $display("FAIL first_tie_cpu: got g=%b%b expected 10", c_gnt, h_gnt);
        end else passed++;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        total++;
        if ({c_rvalid, h_rvalid} !== 2'b10) begin
            $display("FAIL first_tie_rvalid: got %b%b expected 10", c_rvalid, h_rvalid);
        end else passed++;
    endtask

    task automatic test_random();
        logic         locked_m = 1'b0;
        logic         last_m = 1'b0;   // CPU was granted last
        logic         pc = 1'b0, ph = 1'b0, ec, eh;
        logic         cr, cw, hr, hw, hl;
        logic [W-1:0] rd;
        int           c_wait = 0, h_wait = 0;
        for (int n = 0; n < 1000; n++) begin
            cr = 1'($urandom_range(0, 1));
            cw = 1'($urandom_range(0, 1));
            hr = 1'($urandom_range(0, 1));
            hw = 1'($urandom_range(0, 1));
            hl = ($urandom_range(0, 3) == 0);
            rd = W'($urandom_range(0, 255));
            drive(cr, cw, W'(n), 8'hC3, hr, hw, hl, W'(n + 1), 8'h3C, rd);
            if (locked_m) begin
                ec = 1'b0;
                eh = hr;
            end else if (cr && hr) begin
                ec = last_m;
                eh = ~last_m;
            end else begin
                ec = cr;
                eh = hr;
            end
            total++;
            if ({c_gnt, h_gnt} !== {ec, eh}) begin
                $display("FAIL rand_grant @%0d: got %b%b expected %b%b", n, c_gnt, h_gnt, ec, eh);
            end else passed++;
            total++;
            if ((c_gnt & h_gnt) !== 1'b0 || (c_rvalid & h_rvalid) !== 1'b0) begin
                $display("FAIL rand_exclusive @%0d: got g=%b%b rv=%b%b expected no overlap", n, c_gnt, h_gnt, c_rvalid, h_rvalid);
            end else passed++;
            total++;
            if ({c_rvalid, h_rvalid, cpu_stall, rdata} !== {pc, ph, cr & ~ec, rd}) begin
                $display("FAIL rand_rvalid @%0d: got rv=%b%b st=%b rd=%h expected %b%b %b %h", n, c_rvalid, h_rvalid, cpu_stall, rdata, pc, ph, cr & ~ec, rd);
            end else passed++;
            c_wait = (!locked_m && cr && !c_gnt) ? c_wait + 1 : 0;
            h_wait = (!locked_m && hr && !h_gnt) ? h_wait + 1 : 0;
            total++;
            if (c_wait > 1 || h_wait > 1) begin
                $display("FAIL rand_wait @%0d: got waits c=%0d h=%0d expected at most 1", n, c_wait, h_wait);
            end else passed++;
            pc = ec & ~cw;
            ph = eh & ~hw;
            if (ec) last_m = 1'b0;
            else if (eh) last_m = 1'b1;
            locked_m = hl;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
